// File: rtl/rv32im_bus_arbiter.sv
// Two-master Wishbone arbiter with strobe watchdog in front of the shared memory slave.
// Define RV32IM_BUS_ARBITER_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (master 0).
module rv32im_bus_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,

    input  logic            m0_req_i,
    output logic            m0_grant_o,
    input  logic [XLEN-3:0] m0_adr_i,
    input  logic [XLEN-1:0] m0_dat_i,
    input  logic            m0_we_i,
    input  logic [3:0]      m0_sel_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_req_i,
    output logic            m1_grant_o,
    input  logic [XLEN-3:0] m1_adr_i,
    input  logic [XLEN-1:0] m1_dat_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_sel_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [XLEN-1:0] m_dat_o,

    output logic [XLEN-3:0] s_adr_o,
    output logic [XLEN-1:0] s_dat_o,
    output logic            s_we_o,
    output logic [3:0]      s_sel_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [XLEN-1:0] s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] WD_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          m0_grant_q, m1_grant_q;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          own0_c, own1_c;
    logic          pick1_c;
    logic          stall_c, wd_fire_c;

    // Contention resolution: which master wins when IDLE sees a request
`ifdef RV32IM_BUS_ARBITER_ROUND_ROBIN_EN
    logic last_served_q;

    always_comb begin
        pick1_c = m1_req_i & (~m0_req_i | ~last_served_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_served_q <= 1'b1;
        end else if (state_q == IDLE && state_d == OWN0) begin
            last_served_q <= 1'b0;
        end else if (state_q == IDLE && state_d == OWN1) begin
            last_served_q <= 1'b1;
        end
    end
`else
    always_comb begin
        pick1_c = m1_req_i & ~m0_req_i;
    end
`endif

    // State and grant registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == OWN0);
            m1_grant_q <= (state_d == OWN1);
        end
    end

    // Next state: tenure lasts while the owner holds req; IDLE between tenures gives turnaround
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_d = pick1_c ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!m0_req_i) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!m1_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign own0_c     = (state_q == OWN0);
    assign own1_c     = (state_q == OWN1);
    assign m0_grant_o = m0_grant_q;
    assign m1_grant_o = m1_grant_q;

    // Slave-side mux driven by the registered owner
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (own0_c) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
        end else if (own1_c) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
        end
    end

    assign m_dat_o = s_dat_i;

    // Watchdog: expiry only counts on a stalled strobe, so a same-cycle ack suppresses it
    assign stall_c   = s_stb_o & ~s_ack_i & ~s_err_i;
    assign wd_fire_c = stall_c & (wd_cnt_q == WD_LAST);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (!stall_c || wd_fire_c) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Responses reach the owner only
    assign m0_ack_o = own0_c & s_ack_i;
    assign m1_ack_o = own1_c & s_ack_i;
    assign m0_err_o = own0_c & (s_err_i | wd_fire_c);
    assign m1_err_o = own1_c & (s_err_i | wd_fire_c);

endmodule
